// File: rtl/div_issue_ctrl_pkg.sv
// rtl/div_issue_ctrl_pkg.sv - shared QianTang divider-issue encodings and constants
// Holds funct3 opcodes, FSM state encoding and the most-negative operand constants.
package div_issue_ctrl_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [63:0] MOST_NEG_64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MOST_NEG_W  = 64'hFFFF_FFFF_8000_0000;
  localparam logic [63:0] ALL_ONES_64 = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic logic [63:0] word_ext(input logic [31:0] v, input logic sgn);
    return {{32{sgn & v[31]}}, v};
  endfunction

endpackage

// File: rtl/div_issue_ctrl_special_detect.sv
// rtl/div_issue_ctrl_special_detect.sv - operand extension and divide-by-zero / overflow detection
// Purely combinational; evaluated on the raw request before it is latched.
module div_special_detect
  import div_issue_ctrl_pkg::*;
(
  input  logic        sign_i,
  input  logic        word_i,
  input  logic [63:0] rs1_i,
  input  logic [63:0] rs2_i,
  output logic [63:0] dividend_o,
  output logic [63:0] divisor_o,
  output logic        div_zero_o,
  output logic        overflow_o
);

  logic [63:0] min_val;

  always_comb begin
    dividend_o = rs1_i;
    divisor_o  = rs2_i;
    if (word_i) begin
      dividend_o = word_ext(rs1_i[31:0], sign_i);
      divisor_o  = word_ext(rs2_i[31:0], sign_i);
    end
  end

  // W variants overflow on the sign-extended 32-bit minimum, not the 64-bit one.
  assign min_val    = word_i ? MOST_NEG_W : MOST_NEG_64;
  assign div_zero_o = (divisor_o == 64'd0);
  assign overflow_o = sign_i && (divisor_o == ALL_ONES_64) && (dividend_o == min_val);

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - issue/response controller in front of an external iterative Divider
// Optional single-entry result cache enabled by QIANTANG_DIV_RESULT_CACHE_EN.
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  funct3_i,
  input  logic        word_i,
  input  logic [63:0] rs1_i,
  input  logic [63:0] rs2_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_data_o,
  output logic        busy_o,
  output logic        div_start_o,
  output logic        div_sign_o,
  output logic [63:0] div_div_o,
  output logic [63:0] div_divd_o,
  input  logic [63:0] div_q_i,
  input  logic [63:0] div_rem_i,
  input  logic        div_finish_i
);

  state_e      state_q, state_d;
  logic        rem_sel_q, rem_sel_d;
  logic        word_q, word_d;
  logic        sign_q, sign_d;
  logic [63:0] dividend_q, dividend_d;
  logic [63:0] divisor_q, divisor_d;
  logic [63:0] quot_q, quot_d;
  logic [63:0] rem_q, rem_d;

  logic        acc_sign;
  logic        acc_is_rem;
  logic [63:0] ext_divd;
  logic [63:0] ext_div;
  logic        spec_zero;
  logic        spec_ovf;
  logic        cache_hit;
  logic [63:0] cache_quot;
  logic [63:0] cache_rem;
  logic        capture;
  logic [63:0] res_raw;

  assign acc_sign   = !((funct3_i == F3_DIVU) || (funct3_i == F3_REMU));
  assign acc_is_rem = (funct3_i == F3_REM) || (funct3_i == F3_REMU);
  assign capture    = (state_q == ST_WAIT) && div_finish_i;

  div_special_detect u_detect (
    .sign_i     (acc_sign),
    .word_i     (word_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .dividend_o (ext_divd),
    .divisor_o  (ext_div),
    .div_zero_o (spec_zero),
    .overflow_o (spec_ovf)
  );

`ifdef QIANTANG_DIV_RESULT_CACHE_EN
  logic        c_vld_q;
  logic [63:0] c_divd_q;
  logic [63:0] c_div_q;
  logic        c_sign_q;
  logic        c_word_q;
  logic [63:0] c_quot_q;
  logic [63:0] c_rem_q;

  // Keyed on the extended operands so DIV/REM pairs of the same flavour share an entry.
  assign cache_hit  = c_vld_q && (c_divd_q == ext_divd) && (c_div_q == ext_div) &&
                      (c_sign_q == acc_sign) && (c_word_q == word_i);
  assign cache_quot = c_quot_q;
  assign cache_rem  = c_rem_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      c_vld_q  <= 1'b0;
      c_divd_q <= '0;
      c_div_q  <= '0;
      c_sign_q <= 1'b0;
      c_word_q <= 1'b0;
      c_quot_q <= '0;
      c_rem_q  <= '0;
    end else if (capture) begin
      c_vld_q  <= 1'b1;
      c_divd_q <= dividend_q;
      c_div_q  <= divisor_q;
      c_sign_q <= sign_q;
      c_word_q <= word_q;
      c_quot_q <= div_q_i;
      c_rem_q  <= div_rem_i;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_quot = '0;
  assign cache_rem  = '0;
`endif

  always_comb begin
    state_d    = state_q;
    rem_sel_d  = rem_sel_q;
    word_d     = word_q;
    sign_d     = sign_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          rem_sel_d  = acc_is_rem;
          word_d     = word_i;
          sign_d     = acc_sign;
          dividend_d = ext_divd;
          divisor_d  = ext_div;
          if (spec_zero) begin
            quot_d  = ALL_ONES_64;
            rem_d   = ext_divd;
            state_d = ST_RESP;
          end else if (spec_ovf) begin
            quot_d  = ext_divd;
            rem_d   = 64'd0;
            state_d = ST_RESP;
          end else if (cache_hit) begin
            quot_d  = cache_quot;
            rem_d   = cache_rem;
            state_d = ST_RESP;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        if (div_finish_i) begin
          quot_d  = div_q_i;
          rem_d   = div_rem_i;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rem_sel_q  <= 1'b0;
      word_q     <= 1'b0;
      sign_q     <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      state_q    <= state_d;
      rem_sel_q  <= rem_sel_d;
      word_q     <= word_d;
      sign_q     <= sign_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
    end
  end

  assign req_ready_o  = (state_q == ST_IDLE);
  assign busy_o       = (state_q != ST_IDLE);
  assign div_start_o  = (state_q == ST_START);
  assign resp_valid_o = (state_q == ST_RESP);
  assign div_sign_o   = sign_q;
  assign div_div_o    = divisor_q;
  assign div_divd_o   = dividend_q;

  assign res_raw     = rem_sel_q ? rem_q : quot_q;
  assign resp_data_o = word_q ? word_ext(res_raw[31:0], 1'b1) : res_raw;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed self-checking bench for div_issue_ctrl
// Acts as the external Divider; cache expectations follow QIANTANG_DIV_RESULT_CACHE_EN.
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready_o;
  logic [2:0]  funct3;
  logic        word;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        resp_valid_o;
  logic        resp_ready;
  logic [63:0] resp_data_o;
  logic        busy_o;
  logic        div_start_o;
  logic        div_sign_o;
  logic [63:0] div_div_o;
  logic [63:0] div_divd_o;
  logic [63:0] div_q;
  logic [63:0] div_rem;
  logic        div_finish;

  int total = 0;
  int bad   = 0;
  int starts = 0;

  always #5 clk = ~clk;

  div_issue_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .funct3_i     (funct3),
    .word_i       (word),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data_o),
    .busy_o       (busy_o),
    .div_start_o  (div_start_o),
    .div_sign_o   (div_sign_o),
    .div_div_o    (div_div_o),
    .div_divd_o   (div_divd_o),
    .div_q_i      (div_q),
    .div_rem_i    (div_rem),
    .div_finish_i (div_finish)
  );

  always @(posedge clk) if (div_start_o === 1'b1) starts++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic accept(input string tag, input logic [2:0] f3, input logic w,
                        input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    req_valid = 1'b1;
    funct3 = f3;
    word = w;
    rs1 = a;
    rs2 = b;
    chk({tag, ".req_ready"}, req_ready_o, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Called at a negedge where the response must already be presented.
  task automatic take_resp(input string tag, input logic [63:0] exp);
    chk({tag, ".resp_valid"}, resp_valid_o, 1);
    chk({tag, ".resp_data"}, resp_data_o, exp);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".idle_valid"}, resp_valid_o, 0);
    chk({tag, ".idle_ready"}, req_ready_o, 1);
  endtask

  task automatic bypass_op(input string tag, input logic [2:0] f3, input logic w,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
    int s0;
    s0 = starts;
    accept(tag, f3, w, a, b);
    @(negedge clk);
    chk({tag, ".no_start_now"}, div_start_o, 0);
    take_resp(tag, exp);
    chk({tag, ".start_cnt"}, starts - s0, 0);
  endtask

  task automatic normal_op(input string tag, input logic [2:0] f3, input logic w,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] ediv, input logic [63:0] edivd,
                           input logic [63:0] q, input logic [63:0] r,
                           input logic [63:0] exp, input int lag);
    int s0;
    logic esign;
    esign = ~f3[0];
    s0 = starts;
    accept(tag, f3, w, a, b);
    @(negedge clk);
    chk({tag, ".start"}, div_start_o, 1);
    chk({tag, ".busy"}, busy_o, 1);
    chk({tag, ".early_valid"}, resp_valid_o, 0);
    chk({tag, ".div_div"}, div_div_o, ediv);
    chk({tag, ".div_divd"}, div_divd_o, edivd);
    chk({tag, ".div_sign"}, div_sign_o, esign);
    // A stale finish during START must be ignored.
    div_finish = 1'b1;
    div_q = 64'hDEAD_BEEF_DEAD_BEEF;
    div_rem = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    div_finish = 1'b0;
    chk({tag, ".start_drop"}, div_start_o, 0);
    chk({tag, ".in_wait"}, resp_valid_o, 0);
    for (int i = 0; i < lag; i++) begin
      @(negedge clk);
      chk({tag, ".wait_hold"}, resp_valid_o, 0);
    end
    div_q = q;
    div_rem = r;
    div_finish = 1'b1;
    chk({tag, ".div_div_cap"}, div_div_o, ediv);
    chk({tag, ".div_divd_cap"}, div_divd_o, edivd);
    @(negedge clk);
    div_finish = 1'b0;
    div_q = 64'h0BAD_0BAD_0BAD_0BAD;
    div_rem = 64'h0BAD_0BAD_0BAD_0BAD;
    take_resp(tag, exp);
    chk({tag, ".start_cnt"}, starts - s0, 1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    funct3 = 3'b100;
    word = 1'b0;
    rs1 = '0;
    rs2 = '0;
    resp_ready = 1'b0;
    div_q = '0;
    div_rem = '0;
    div_finish = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.req_ready", req_ready_o, 1);
    chk("rst.busy", busy_o, 0);
    chk("rst.resp_valid", resp_valid_o, 0);
    chk("rst.resp_data", resp_data_o, 0);
    chk("rst.start", div_start_o, 0);
    chk("rst.sign", div_sign_o, 0);
    chk("rst.div_div", div_div_o, 0);
    chk("rst.div_divd", div_divd_o, 0);

    normal_op("divu_100_7", 3'b101, 1'b0, 64'd100, 64'd7, 64'd7, 64'd100,
              64'd14, 64'd2, 64'd14, 2);
    normal_op("div_m7_2", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              64'd2, 64'hFFFF_FFFF_FFFF_FFF9,
              64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFD, 0);
    normal_op("remu_100_7", 3'b111, 1'b0, 64'd100, 64'd7, 64'd7, 64'd100,
              64'd14, 64'd2, 64'd2, 1);
    normal_op("rem_m7_2", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
              64'd2, 64'hFFFF_FFFF_FFFF_FFF9,
              64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFF, 3);

    bypass_op("divu_x_0", 3'b101, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    bypass_op("rem_5_0", 3'b110, 1'b0, 64'd5, 64'd0, 64'd5);
    bypass_op("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
    bypass_op("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000,
              64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    bypass_op("divw_ovf", 3'b100, 1'b1, 64'h0000_0000_8000_0000,
              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);

    normal_op("divw_m7_2", 3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hAAAA_AAAA_0000_0002,
              64'd2, 64'hFFFF_FFFF_FFFF_FFF9,
              64'h0000_0000_FFFF_FFFD, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFD, 1);
    normal_op("divuw_min_1", 3'b101, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1,
              64'd1, 64'h0000_0000_8000_0000,
              64'h0000_0000_8000_0000, 64'd0,
              64'hFFFF_FFFF_8000_0000, 0);

    accept("stall", 3'b101, 1'b0, 64'd9, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall.valid", resp_valid_o, 1);
      chk("stall.data", resp_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
    end
    @(negedge clk);
    take_resp("stall", 64'hFFFF_FFFF_FFFF_FFFF);

    accept("abort", 3'b101, 1'b0, 64'd50, 64'd5);
    @(negedge clk);
    chk("abort.start", div_start_o, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort.busy", busy_o, 0);
    chk("abort.req_ready", req_ready_o, 1);
    chk("abort.resp_valid", resp_valid_o, 0);
    chk("abort.div_div", div_div_o, 0);
    chk("abort.div_divd", div_divd_o, 0);
    div_q = 64'd10;
    div_rem = 64'd0;
    div_finish = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort.no_resp", resp_valid_o, 0);
      chk("abort.no_start", div_start_o, 0);
    end
    div_finish = 1'b0;
    normal_op("after_abort", 3'b101, 1'b0, 64'd50, 64'd5, 64'd5, 64'd50,
              64'd10, 64'd0, 64'd10, 2);

    normal_op("div_1000_3", 3'b100, 1'b0, 64'd1000, 64'd3, 64'd3, 64'd1000,
              64'd333, 64'd1, 64'd333, 1);
`ifdef QIANTANG_DIV_RESULT_CACHE_EN
    bypass_op("rem_1000_3_hit", 3'b110, 1'b0, 64'd1000, 64'd3, 64'd1);
`else
    normal_op("rem_1000_3", 3'b110, 1'b0, 64'd1000, 64'd3, 64'd3, 64'd1000,
              64'd333, 64'd1, 64'd1, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_issue_ctrl.md
DIV_ISSUE_CTRL -- requirements
Module: div_issue_ctrl

Interface
REQ-001 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-002 rst_i  input  1  reset, synchronous, active-high.
REQ-003 req_valid_i / req_ready_o  in/out  1/1  request handshake; transfer when both are high.
REQ-004 funct3_i  input  3  opcode: 100 DIV, 101 DIVU, 110 REM, 111 REMU; other values are never driven.
REQ-005 word_i  input  1  W variant: 32-bit operation, 64-bit sign-extended result.
REQ-006 rs1_i / rs2_i  input  64/64  dividend / divisor.
REQ-007 resp_valid_o / resp_ready_i  out/in  1/1  response handshake.
REQ-008 resp_data_o  output  64  quotient or remainder.
REQ-009 busy_o  output  1  high in any state other than IDLE.
REQ-010 div_start_o, div_sign_o  output  1/1  drive the Divider start and sign-control inputs.
REQ-011 div_div_o / div_divd_o  output  64/64  drive the Divider divisor / dividend inputs.
REQ-012 div_q_i, div_rem_i, div_finish_i  input  64/64/1  Divider quotient, remainder and finish outputs.

Function
REQ-013 FSM states: IDLE, START, WAIT, RESP; req_ready_o=1 only in IDLE.
REQ-014 Accept in IDLE: latch funct3, word and operands into registers.
- Accepted operands are preprocessed: if word_i=1, low 32 bits are sign-extended for DIV/REM and zero-extended for DIVU/REMU.
- div_sign_o = ~funct3[0].
REQ-015 Divide-by-zero (preprocessed divisor == 0) bypasses the Divider.
- Quotient = all ones; remainder = preprocessed dividend.
- FSM goes IDLE->RESP; resp_valid_o is high the cycle after acceptance.
REQ-016 Signed overflow bypasses the Divider the same way.
- Condition: signed op, dividend = most-negative value (2^63, or 2^31 sign-extended when word), divisor = -1.
- Quotient = dividend; remainder = 0.
REQ-017 Normal path: IDLE->START.
- In START, div_start_o=1 for exactly one cycle, then START->WAIT.
- div_start_o is 0 in every other state, so the Divider edge detector sees a fresh rising edge for each request.
REQ-018 div_finish_i is ignored in START and sampled from the first WAIT cycle.
- In WAIT, div_finish_i=1 captures div_q_i and div_rem_i, then WAIT->RESP.
REQ-019 div_div_o, div_divd_o and div_sign_o hold the latched values, stable from START through the capture cycle.
REQ-020 resp_data_o = quotient for funct3[1]=0, remainder for funct3[1]=1.
- If word=1, resp_data_o = {32{r[31]}, r[31:0]}.
REQ-021 RESP: resp_valid_o=1 and resp_data_o stable until resp_ready_i=1, then RESP->IDLE; no new request is accepted in that cycle.
REQ-022 Latency:
- Bypass: accept at cycle N, resp_valid_o at N+1.
- Normal: accept at N, start at N+1, finish first sampled at N+2; finish seen at cycle M gives resp_valid_o at M+1.
REQ-023 No timeout: WAIT is held indefinitely until finish.

Reset
REQ-024 rst_i=1 forces IDLE and clears all outputs to 0 except req_ready_o, which is 1 from the first post-reset cycle.
REQ-025 Reset mid-operation (START/WAIT/RESP) drops the in-flight request with no response.
- Any Divider activity still running is ignored; the next accepted request restarts the Divider.

Configuration
REQ-026 Macro QIANTANG_DIV_RESULT_CACHE_EN, when defined, keeps one entry: valid, operands, sign, word, quotient, remainder.
- The entry is written on each normal-path capture and cleared on reset.
- A request matching all four keys (operands, sign, word) skips the Divider and responds at N+1 like a bypass.
- This lets REM follow DIV cheaply.
REQ-027 Without QIANTANG_DIV_RESULT_CACHE_EN, no cache storage exists and every non-special request takes the normal path.

Structure
REQ-028 funct3 encodings, state encodings and the 64-bit most-negative constant belong in the shared QianTang header.
REQ-029 One combinational sub-module, div_special_detect, holds operand extension and the zero/overflow detection.
REQ-030 The Divider is instantiated by the parent, not inside this block.

Verification
REQ-031 DIVU 100/7 → resp_data_o=14; REMU 100/7 → 2; div_start_o high exactly one cycle per request.
REQ-032 DIV -7/2 → 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 → 0xFFFF_FFFF_FFFF_FFFF.
REQ-033 DIVU x/0 → all ones at N+1 with no div_start_o pulse; REM 5/0 → 5.
REQ-034 DIV 0x8000_0000_0000_0000/-1 → 0x8000_0000_0000_0000; REM of the same operands → 0; DIVW 0x8000_0000/-1 → 0xFFFF_FFFF_8000_0000.
REQ-035 resp_ready_i held low 5 cycles → resp_valid_o and resp_data_o stable throughout; rst_i pulsed during WAIT → IDLE next cycle, no response, and a following request completes correctly.
REQ-036 With QIANTANG_DIV_RESULT_CACHE_EN: DIV 1000/3 then REM 1000/3 → second returns 1 at N+1 with no start pulse.
